// File: rtl/mem_access_pkg.sv
// Shared memory-stage encodings: minst opcodes, access sizes, FSM states and
// exception causes, plus the alignment/legality check used by mem_access.
package mem_access_pkg;

  localparam logic [3:0] MINST_NONE = 4'b1100;
  localparam logic [3:0] MINST_LB   = 4'b0000;
  localparam logic [3:0] MINST_LH   = 4'b0001;
  localparam logic [3:0] MINST_LW   = 4'b0010;
  localparam logic [3:0] MINST_LBU  = 4'b0100;
  localparam logic [3:0] MINST_LHU  = 4'b0101;
  localparam logic [3:0] MINST_SB   = 4'b1000;
  localparam logic [3:0] MINST_SH   = 4'b1001;
  localparam logic [3:0] MINST_SW   = 4'b1010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } mem_state_e;

  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_LD_MISAL = 2'b01;
  localparam logic [1:0] EXC_ST_MISAL = 2'b10;
  localparam logic [1:0] EXC_ILLEGAL  = 2'b11;

  // Illegal size beats misalignment; non-memory ops never raise anything.
  function automatic logic [1:0] mem_check(input logic [3:0] minst, input logic [1:0] lane);
    logic illegal;
    logic misal;
    illegal = (minst[1:0] == 2'b11) || (!minst[3] && minst[2] && minst[1]);
    misal   = ((minst[1:0] == 2'b01) && lane[0]) ||
              ((minst[1:0] == 2'b10) && (lane != 2'b00));
    if (minst[3:2] == 2'b11) begin
      mem_check = EXC_NONE;
    end else if (illegal) begin
      mem_check = EXC_ILLEGAL;
    end else if (misal) begin
      mem_check = minst[3] ? EXC_ST_MISAL : EXC_LD_MISAL;
    end else begin
      mem_check = EXC_NONE;
    end
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for the data-memory bus: store byte enables and
// replicated write data, and load lane extraction with sign/zero extension.
module mem_align (
  input  logic [2:0]  size,
  input  logic [1:0]  lane,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  logic [31:0] shifted_s;

  // Steer store lanes and extract/extend the addressed load lane.
  always_comb begin
    be        = 4'b0000;
    wdata     = 32'h0000_0000;
    ld_data   = 32'h0000_0000;
    shifted_s = rdata >> {lane, 3'b000};
    case (size[1:0])
      2'b00: begin
        be      = 4'b0001 << lane;
        wdata   = {4{st_data[7:0]}};
        ld_data = size[2] ? {24'h00_0000, shifted_s[7:0]}
                          : {{24{shifted_s[7]}}, shifted_s[7:0]};
      end
      2'b01: begin
        be      = 4'b0011 << lane;
        wdata   = {2{st_data[15:0]}};
        ld_data = size[2] ? {16'h0000, shifted_s[15:0]}
                          : {{16{shifted_s[15]}}, shifted_s[15:0]};
      end
      2'b10: begin
        be      = 4'b1111;
        wdata   = st_data;
        ld_data = rdata;
      end
      default: begin
        be      = 4'b0000;
        wdata   = 32'h0000_0000;
        ld_data = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// RV32IM memory stage: issues one gnt/rvalid data-memory access per captured
// op, stalls the pipe until it completes, and produces writeback/exception.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [3:0]    minst,
  input  logic [31:0]   addr,
  input  logic [31:0]   st_data,
  input  logic [4:0]    rd,
  input  logic          rdm_v,
  output logic          stall_o,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [3:0]    dmem_be,
  output logic [31:0]   dmem_wdata,
  input  logic          dmem_gnt,
  input  logic          dmem_rvalid,
  input  logic [31:0]   dmem_rdata,
  output logic          wb_v,
  output logic [4:0]    wb_rd,
  output logic [31:0]   wb_data,
  output logic          exc_o,
  output logic [1:0]    exc_cause
);

  logic [3:0]  m_minst_r;
  logic [31:0] m_addr_r;
  logic [31:0] m_data_r;
  logic [4:0]  m_rd_r;
  logic        m_rdm_v_r;
  // Cleared once a store completes from REQ, since the held op must not reissue.
  logic        m_pend_r;
  mem_state_e  state_r;

  logic [1:0]  cause_s;
  logic        is_mem_s;
  logic        is_store_s;
  logic        act_s;
  logic        req_s;
  logic        stall_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s;
  logic [31:0] ld_data_s;

  mem_align u_align (
    .size    (m_minst_r[2:0]),
    .lane    (m_addr_r[1:0]),
    .st_data (m_data_r),
    .rdata   (dmem_rdata),
    .be      (be_s),
    .wdata   (wdata_s),
    .ld_data (ld_data_s)
  );

  // Decode the held op and derive request/stall for the current state.
  always_comb begin
    cause_s    = mem_check(m_minst_r, m_addr_r[1:0]);
    is_mem_s   = (m_minst_r[3:2] != 2'b11);
    is_store_s = m_minst_r[3];
    act_s      = m_pend_r && is_mem_s && (cause_s == EXC_NONE);
    req_s      = 1'b0;
    stall_s    = 1'b0;
    case (state_r)
      IDLE: begin
        req_s   = act_s;
        stall_s = act_s && (!dmem_gnt || !is_store_s);
      end
      REQ: begin
        req_s   = 1'b1;
        stall_s = 1'b1;
      end
      RESP: begin
        req_s   = 1'b0;
        stall_s = !dmem_rvalid;
      end
      default: begin
        req_s   = 1'b0;
        stall_s = 1'b0;
      end
    endcase
  end

  assign stall_o    = stall_s;
  assign dmem_req   = req_s;
  assign dmem_we    = req_s && is_store_s;
  assign dmem_addr  = req_s ? {m_addr_r[AW-1:2], 2'b00} : {AW{1'b0}};
  assign dmem_be    = req_s ? be_s : 4'b0000;
  assign dmem_wdata = (req_s && is_store_s) ? wdata_s : 32'h0000_0000;

  // Access FSM: IDLE issues, REQ waits for gnt, RESP waits for rvalid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (act_s && !dmem_gnt) begin
            state_r <= REQ;
          end else if (act_s && !is_store_s) begin
            state_r <= RESP;
          end else begin
            state_r <= IDLE;
          end
        end
        REQ: begin
          if (dmem_gnt) begin
            state_r <= is_store_s ? IDLE : RESP;
          end else begin
            state_r <= REQ;
          end
        end
        RESP: begin
          if (dmem_rvalid) begin
            state_r <= IDLE;
          end else begin
            state_r <= RESP;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // M-stage pipeline registers, captured whenever the stage is not stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_minst_r <= MINST_NONE;
      m_addr_r  <= 32'h0000_0000;
      m_data_r  <= 32'h0000_0000;
      m_rd_r    <= 5'd0;
      m_rdm_v_r <= 1'b0;
      m_pend_r  <= 1'b0;
    end else if (!stall_s) begin
      m_minst_r <= minst;
      m_addr_r  <= addr;
      m_data_r  <= st_data;
      m_rd_r    <= rd;
      m_rdm_v_r <= rdm_v;
      m_pend_r  <= 1'b1;
    end else if ((state_r == REQ) && dmem_gnt && is_store_s) begin
      m_pend_r  <= 1'b0;
    end else begin
      m_pend_r  <= m_pend_r;
    end
  end

  // Registered writeback and exception outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_v      <= 1'b0;
      wb_rd     <= 5'd0;
      wb_data   <= 32'h0000_0000;
      exc_o     <= 1'b0;
      exc_cause <= EXC_NONE;
    end else begin
      if ((state_r == RESP) && dmem_rvalid) begin
        wb_v    <= m_rdm_v_r;
        wb_rd   <= m_rd_r;
        wb_data <= ld_data_s;
      end else if ((state_r == IDLE) && m_pend_r && !is_mem_s) begin
        wb_v    <= m_rdm_v_r;
        wb_rd   <= m_rd_r;
        wb_data <= m_addr_r;
      end else begin
        wb_v    <= 1'b0;
      end
      if ((state_r == IDLE) && m_pend_r && (cause_s != EXC_NONE)) begin
        exc_o     <= 1'b1;
        exc_cause <= cause_s;
      end else begin
        exc_o     <= 1'b0;
        exc_cause <= EXC_NONE;
      end
    end
  end

endmodule
